// File: rtl/game_over_screen_pkg.sv
// Shared constants, pixel bundle type and banner lookup for the game-over overlay.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_over_screen_pkg;

  localparam int HOR_PIX = 1024;
  localparam int VER_PIX = 768;
  localparam int RGB_W   = 12;

  localparam logic [1:0] ST_PLAY      = 2'd0;
  localparam logic [1:0] ST_OVER_WAIT = 2'd1;
  localparam logic [1:0] ST_OVER_SHOW = 2'd2;

  localparam int BANNER_LEN = 9;
  localparam logic [8*BANNER_LEN-1:0] BANNER = "GAME OVER";

  // Timing plus pixel, carried down the pipeline as one word
  typedef struct packed {
    logic [10:0]      hcount;
    logic [10:0]      vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

  // 7-bit ASCII of the banner character at idx; anything past the end is a space
  function automatic logic [6:0] banner_char(input logic [3:0] idx);
    logic [6:0] c;
    c = 7'h20;
    for (int i = 0; i < BANNER_LEN; i++) begin
      if (idx == 4'(i)) c = BANNER[8*(BANNER_LEN-1-i) +: 7];
    end
    return c;
  endfunction

endpackage

// File: rtl/game_over_screen_font_rom.sv
// 8x16 font ROM holding the glyphs the banner needs; other codes read as blank.
// Latency: 1 clock from addr to data.
// Backpressure: none, one read per clock.
module game_over_screen_font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [127:0] w_glyph;
  logic [7:0]   r_data;

  // Glyph select by character code; line 0 is the most significant byte
  always_comb begin
    case (addr[10:4])
      7'h47:   w_glyph = 128'h0000_3C66_C2C0_C0DE_C6C6_663A_0000_0000; // G
      7'h41:   w_glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000; // A
      7'h4D:   w_glyph = 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000; // M
      7'h45:   w_glyph = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000; // E
      7'h4F:   w_glyph = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000; // O
      7'h56:   w_glyph = 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000; // V
      7'h52:   w_glyph = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000; // R
      default: w_glyph = '0;
    endcase
  end

  // Registered read of the addressed glyph line
  always_ff @(posedge clk) begin
    r_data <= w_glyph[8*(15 - int'(addr[3:0])) +: 8];
  end

  assign data = r_data;

endmodule

// File: rtl/game_over_screen.sv
// Latches game over, freezes play, overlays a blinking banner, and issues a restart pulse.
// Latency: 2 clocks from every *_in to the matching *_out, in all states.
// Backpressure: none; the VGA stream is free-running and never stalled.
module game_over_screen
  import game_over_screen_pkg::*;
#(
  parameter int               TEXT_X          = 440,
  parameter int               TEXT_Y          = 368,
  parameter logic [RGB_W-1:0] TEXT_RGB        = 12'hF00,
  parameter int               BLINK_FRAMES    = 32,
  parameter int               MIN_OVER_FRAMES = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      hcount_in,
  input  logic [10:0]      vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             game_over_in,
  input  logic             restart_in,
  output logic [10:0]      hcount_out,
  output logic [10:0]      vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             play_en,
  output logic             game_reset
);

  localparam int BANNER_W = BANNER_LEN * 16;
  localparam int BANNER_H = 32;
  localparam int FW = $clog2(MIN_OVER_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [1:0]    r_state;
  logic [FW-1:0] r_frame_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          r_vsync_q;
  logic          r_restart_q;
  logic          r_game_reset;
  logic          w_tick;
  logic          w_restart_edge;

  vga_t          w_in;
  vga_t          r_s1;
  vga_t          r_s2;
  logic          w_in_box;
  logic [3:0]    w_char_idx;
  logic [3:0]    w_line;
  logic [2:0]    w_col;
  logic          r_in_box;
  logic          r_in_box_d;
  logic [2:0]    r_col;
  logic [2:0]    r_col_d;
  logic [10:0]   r_rom_addr;
  logic [7:0]    w_rom_data;
  logic          w_pix;

  assign w_tick         = vsync_in & ~r_vsync_q;
  assign w_restart_edge = restart_in & ~r_restart_q;

  // Game state: latch game over, start the overlay on a frame edge, gate restart
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_PLAY;
      r_frame_cnt  <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_vsync_q    <= 1'b0;
      r_restart_q  <= 1'b0;
      r_game_reset <= 1'b0;
    end else begin
      r_vsync_q    <= vsync_in;
      r_restart_q  <= restart_in;
      r_game_reset <= 1'b0;
      case (r_state)
        ST_PLAY: begin
          if (game_over_in) r_state <= ST_OVER_WAIT;
        end
        ST_OVER_WAIT: begin
          if (w_tick) begin
            r_state     <= ST_OVER_SHOW;
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
          end
        end
        ST_OVER_SHOW: begin
          // Early restart edges are dropped here, never remembered
          if (w_restart_edge && r_frame_cnt == FW'(MIN_OVER_FRAMES)) begin
            r_state      <= ST_PLAY;
            r_game_reset <= 1'b1;
          end else if (w_tick) begin
            if (r_frame_cnt != FW'(MIN_OVER_FRAMES)) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
              r_blink_cnt <= '0;
              r_phase     <= ~r_phase;
            end else begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_PLAY;
      endcase
    end
  end

  // Banner geometry; the box is also clipped to the visible area
  assign w_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
  assign w_in_box = (hcount_in >= 11'(TEXT_X)) && (hcount_in < 11'(TEXT_X + BANNER_W)) &&
                    (vcount_in >= 11'(TEXT_Y)) && (vcount_in < 11'(TEXT_Y + BANNER_H)) &&
                    (hcount_in < 11'(HOR_PIX)) && (vcount_in < 11'(VER_PIX));
  assign w_char_idx = 4'((hcount_in - 11'(TEXT_X)) >> 4);
  assign w_col      = 3'((hcount_in - 11'(TEXT_X)) >> 1);
  assign w_line     = 4'((vcount_in - 11'(TEXT_Y)) >> 1);

  // Two-stage pipeline: stage 1 forms the ROM address, stage 2 aligns with ROM data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_in_box   <= 1'b0;
      r_in_box_d <= 1'b0;
      r_col      <= '0;
      r_col_d    <= '0;
      r_rom_addr <= '0;
    end else begin
      r_s1       <= w_in;
      r_in_box   <= w_in_box;
      r_col      <= w_col;
      r_rom_addr <= {banner_char(w_char_idx), w_line};
      r_s2       <= r_s1;
      r_in_box_d <= r_in_box;
      r_col_d    <= r_col;
    end
  end

  game_over_screen_font_rom u_font_rom (
    .clk  (clk),
    .addr (r_rom_addr),
    .data (w_rom_data)
  );

  assign w_pix = w_rom_data[3'd7 - r_col_d];

  // Output pixel: blanking first, then the banner, else the upstream pixel
  always_comb begin
    rgb_out = r_s2.rgb;
    if (r_s2.hblnk || r_s2.vblnk) begin
      rgb_out = '0;
    end else if (r_state == ST_OVER_SHOW && r_phase && r_in_box_d && w_pix) begin
      rgb_out = TEXT_RGB;
    end
  end

  assign hcount_out = r_s2.hcount;
  assign vcount_out = r_s2.vcount;
  assign hsync_out  = r_s2.hsync;
  assign vsync_out  = r_s2.vsync;
  assign hblnk_out  = r_s2.hblnk;
  assign vblnk_out  = r_s2.vblnk;
  assign play_en    = (r_state == ST_PLAY);
  assign game_reset = r_game_reset;

endmodule

// File: tb/tb_game_over_screen.sv
// Scoreboard bench for game_over_screen: per-cycle expected outputs vs. DUT.
// Latency: expectations are queued at drive time and retired 2 clocks later.
// Backpressure: none.
module tb_game_over_screen;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        game_over_in, restart_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        play_en, game_reset;

  game_over_screen dut (
    .clk          (clk),
    .rst          (rst),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .hblnk_in     (hblnk_in),
    .vblnk_in     (vblnk_in),
    .rgb_in       (rgb_in),
    .game_over_in (game_over_in),
    .restart_in   (restart_in),
    .hcount_out   (hcount_out),
    .vcount_out   (vcount_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .hblnk_out    (hblnk_out),
    .vblnk_out    (vblnk_out),
    .rgb_out      (rgb_out),
    .play_en      (play_en),
    .game_reset   (game_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    bit          inb, pix;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   hits   = 0;
  int   ones4  = 0;

  // Reference model of the control state
  int   m_state = 0;
  int   m_fcnt  = 0;
  int   m_bcnt  = 0;
  bit   m_phase = 0;
  bit   m_vs_q  = 0;
  bit   m_rs_q  = 0;
  bit   m_gr    = 0;

  logic [127:0] glyph [9];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit in_box(input int h, input int v);
    return (h >= 440) && (h < 584) && (v >= 368) && (v < 400);
  endfunction

  function automatic bit glyph_bit(input int h, input int v);
    logic [127:0] g;
    logic [7:0]   row;
    int           dx, line;
    if (!in_box(h, v)) return 1'b0;
    dx   = h - 440;
    line = (v - 368) / 2;
    g    = glyph[dx / 16];
    row  = g[8*(15-line) +: 8];
    return row[7 - (dx % 16) / 2];
  endfunction

  function automatic logic [11:0] rnd();
    return 12'($urandom_range(0, 12'hEFF));
  endfunction

  task automatic model_update();
    bit tick, redge;
    if (rst) begin
      m_state = 0; m_fcnt = 0; m_bcnt = 0; m_phase = 0;
      m_vs_q = 0; m_rs_q = 0; m_gr = 0;
    end else begin
      tick  = vsync_in && !m_vs_q;
      redge = restart_in && !m_rs_q;
      m_gr  = 0;
      case (m_state)
        0: if (game_over_in) m_state = 1;
        1: if (tick) begin m_state = 2; m_fcnt = 0; m_bcnt = 0; m_phase = 1; end
        default: begin
          if (redge && m_fcnt == 60) begin
            m_state = 0; m_gr = 1;
          end else if (tick) begin
            if (m_fcnt < 60) m_fcnt++;
            if (m_bcnt == 31) begin m_bcnt = 0; m_phase = !m_phase; end
            else m_bcnt++;
          end
        end
      endcase
      m_vs_q = vsync_in;
      m_rs_q = restart_in;
    end
  endtask

  // One clock: queue expectation, update model at the edge, compare on the falling edge
  task automatic step();
    exp_t e, z;
    logic [11:0] exp_rgb;
    e.hc = hcount_in; e.vc = vcount_in;
    e.hs = hsync_in; e.vs = vsync_in; e.hb = hblnk_in; e.vb = vblnk_in;
    e.rgb = rgb_in;
    e.inb = in_box(int'(hcount_in), int'(vcount_in));
    e.pix = glyph_bit(int'(hcount_in), int'(vcount_in));
    sb.push_back(e);
    @(posedge clk);
    model_update();
    if (rst) begin
      z = '{default: 0};
      sb.delete();
      sb.push_back(z);
      sb.push_back(z);
    end
    @(negedge clk);
    if (sb.size() > 1) begin
      e = sb.pop_front();
      if (e.hb || e.vb) exp_rgb = 12'h000;
      else if (m_state == 2 && m_phase && e.inb && e.pix) exp_rgb = 12'hF00;
      else exp_rgb = e.rgb;
      chk("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'({e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}));
      chk("rgb", 32'(rgb_out), 32'(exp_rgb));
      chk("play_en", 32'(play_en), 32'(m_state == 0));
      chk("game_reset", 32'(game_reset), 32'(m_gr));
      if (rgb_out == 12'hF00) hits++;
    end
  endtask

  task automatic vsync_pulse();
    hcount_in = 11'd0; vcount_in = 11'd770; hsync_in = 1'b0; hblnk_in = 1'b0;
    vblnk_in = 1'b1; vsync_in = 1'b1; rgb_in = rnd();
    step();
    rgb_in = rnd();
    step();
    vsync_in = 1'b0; rgb_in = rnd();
    step();
    vblnk_in = 1'b0;
  endtask

  // Sweep the banner area (all rows, or a few sample lines) and check visibility
  task automatic scan(input bit full, input bit present);
    hits = 0;
    for (int r = 0; r < 32; r++) begin
      if (!full && !(r == 0 || r == 1 || r == 6 || r == 15)) continue;
      vcount_in = 11'(368 + r);
      for (int h = 436; h < 588; h++) begin
        hcount_in = 11'(h);
        hblnk_in  = (h >= 584);
        hsync_in  = (h >= 586);
        rgb_in    = rnd();
        step();
      end
    end
    hblnk_in = 1'b0; hsync_in = 1'b0; hcount_in = 11'd0; vcount_in = 11'd0;
    step();
    step();
    if (full) chk("banner_px", 32'(hits), present ? 32'(ones4) : 32'd0);
    else      chk("banner_vis", 32'(hits > 0), 32'(present));
  endtask

  task automatic pulse_restart(input bit accept);
    restart_in = 1'b1;
    step();
    chk("restart_pulse", 32'(game_reset), 32'(accept));
    chk("restart_play_en", 32'(play_en), 32'(accept));
    restart_in = 1'b0;
    step();
    chk("pulse_one_cycle", 32'(game_reset), 32'd0);
  endtask

  initial begin
    glyph[0] = 128'h0000_3C66_C2C0_C0DE_C6C6_663A_0000_0000; // G
    glyph[1] = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000; // A
    glyph[2] = 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000; // M
    glyph[3] = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000; // E
    glyph[4] = 128'h0;                                      // space
    glyph[5] = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000; // O
    glyph[6] = 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000; // V
    glyph[7] = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000; // E
    glyph[8] = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000; // R
    for (int c = 0; c < 9; c++) ones4 += 4 * $countones(glyph[c]);

    rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0; game_over_in = 0; restart_in = 0;
    repeat (3) step();
    chk("rst_play_en", 32'(play_en), 32'd1);
    chk("rst_game_reset", 32'(game_reset), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    chk("rst_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
    rst = 1'b0;

    // Plain passthrough
    hcount_in = 11'd100; vcount_in = 11'd100; rgb_in = 12'h0F0;
    repeat (3) step();
    chk("pass_rgb", 32'(rgb_out), 32'h0F0);
    chk("pass_hcount", 32'(hcount_out), 32'd100);
    scan(1'b0, 1'b0);

    // Game over mid-frame: play stops, banner waits for the next frame
    hcount_in = 11'd100; vcount_in = 11'd200; game_over_in = 1'b1;
    step();
    game_over_in = 1'b0;
    step();
    chk("play_en_drop", 32'(play_en), 32'd0);
    scan(1'b0, 1'b0);
    vsync_pulse();                         // frame 0
    scan(1'b1, 1'b1);
    for (int f = 1; f <= 10; f++) vsync_pulse();
    pulse_restart(1'b0);                   // frame 10: too early
    for (int f = 11; f <= 31; f++) vsync_pulse();
    scan(1'b0, 1'b1);
    vsync_pulse();                         // frame 32: blink off
    scan(1'b0, 1'b0);
    for (int f = 33; f <= 64; f++) vsync_pulse();
    scan(1'b0, 1'b1);                      // frame 64: back on
    pulse_restart(1'b1);                   // counter saturated at 60

    // Game over beats a simultaneous restart
    game_over_in = 1'b1; restart_in = 1'b1;
    step();
    chk("go_wins_play_en", 32'(play_en), 32'd0);
    chk("go_wins_reset", 32'(game_reset), 32'd0);
    restart_in = 1'b0;                     // game_over stays high
    vsync_pulse();                         // frame 0
    for (int f = 1; f <= 59; f++) vsync_pulse();
    pulse_restart(1'b0);                   // frame 59: one short
    vsync_pulse();                         // frame 60
    pulse_restart(1'b1);
    chk("reenter_wait", 32'(play_en), 32'd0);
    game_over_in = 1'b0;

    // Reset in the middle of the overlay
    vsync_pulse();
    scan(1'b0, 1'b1);
    hcount_in = 11'd450; vcount_in = 11'd380; rgb_in = rnd();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_play_en", 32'(play_en), 32'd1);
    chk("midrst_game_reset", 32'(game_reset), 32'd0);
    chk("midrst_rgb", 32'(rgb_out), 32'd0);
    scan(1'b0, 1'b0);
    vsync_pulse();
    scan(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_over_screen.md
Name: game_over_screen

Overview:
- Consumer side of the collision flag: latches `game_over`, freezes play, and overlays a blinking "GAME OVER" banner on the VGA stream.
- Waits for a restart press, then issues a one-cycle game reset pulse.
- Sits in the VGA pipeline after the collision detector and before the VGA output register stage.
- Passes all timing signals through with fixed 2-cycle latency.

Parameters:
- TEXT_X, 440: left pixel of banner; banner is 9 chars x 16 px = 144 px wide.
- TEXT_Y, 368: top pixel of banner; banner is 32 px tall (8x16 font scaled x2).
- TEXT_RGB, 12'hF00: banner foreground colour.
- BLINK_FRAMES, 32: frames per blink phase (on/off).
- MIN_OVER_FRAMES, 60: frames in OVER_SHOW before restart is accepted.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- hcount_in, vcount_in  in  11 each  pixel counters.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing.
- rgb_in  in  12  upstream pixel.
- game_over_in  in  1  level from collision detector.
- restart_in  in  1  debounced button level.
- hcount_out, vcount_out  out  11  timing delayed 2 cycles.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  timing delayed 2 cycles.
- rgb_out  out  12  composed pixel.
- play_en  out  1  high only in PLAY.
- game_reset  out  1  one-cycle restart pulse.

Behaviour:
- Reset: all outputs 0 except play_en = 1. State = PLAY; counters = 0; edge-detect registers = 0.
- Frame tick: vsync_in 0→1 edge, detected against a registered copy of vsync_in.
- PLAY: game_over_in = 1 → OVER_WAIT, play_en drops the next cycle. restart_in is ignored. game_over_in wins over a simultaneous restart.
- OVER_WAIT: on frame tick → OVER_SHOW; frame_cnt = 0; blink phase = on. This makes the overlay begin on a frame boundary.
- OVER_SHOW:
  - frame_cnt increments per tick and saturates at MIN_OVER_FRAMES.
  - Blink counter wraps at BLINK_FRAMES−1 and toggles the phase on wrap.
  - Restart rising edge with frame_cnt == MIN_OVER_FRAMES → state PLAY, game_reset = 1 for exactly one cycle, play_en = 1 the same cycle.
  - Restart edges earlier than that are discarded, not queued.
- game_over_in is ignored outside PLAY. If it is still high on return to PLAY, the block re-enters OVER_WAIT the next cycle.
- Pipeline stage 1 (registered):
  - in_box = hcount ∈ [TEXT_X, TEXT_X+144) and vcount ∈ [TEXT_Y, TEXT_Y+32).
  - dx = hcount−TEXT_X, dy = vcount−TEXT_Y, both 8-bit.
  - char_idx = dx[7:4] (0..8); col = dx[3:1]; line = dy[4:1].
  - char_code is the ASCII of "GAME OVER"[char_idx], with a space at index 4.
  - ROM address = {char_code[6:0], line}.
- Pipeline stage 2: ROM data returns (1-cycle ROM); pixel = rom_data[7−col_d]. col_d, in_box_d and all timing are registered alongside.
- rgb_out priority:
  1. 0 if hblnk or vblnk (delayed).
  2. TEXT_RGB if state ∈ {OVER_SHOW}, phase on, in_box_d and pixel = 1.
  3. Otherwise delayed rgb_in.
- Latency: exactly 2 clocks from any *_in to the matching *_out in every state.
- Reset mid-OVER_SHOW: back to PLAY with no game_reset pulse; the pipeline contents are zeroed.

Decomposition:
- Shared package/header: HOR_PIX 1024, VER_PIX 768, RGB width 12, state encoding (PLAY=2'd0, OVER_WAIT=2'd1, OVER_SHOW=2'd2), banner string constant.
- Sub-module: font_rom (addr 11-bit, 8-bit line output, registered, 1-cycle read) — reuse the existing font ROM.

Test Plan:
- Reset for 3 cycles → play_en=1, game_reset=0, rgb_out=0, timing outputs 0. Release; drive rgb_in=12'h0F0 at hcount=100, vcount=100 → 2 cycles later rgb_out=12'h0F0 and hcount_out=100.
- Pulse game_over_in mid-frame → play_en=0 next cycle. No banner pixels until the next vsync edge; in the following frame, pixels at (440..583, 368..399) with ROM bit=1 show 12'hF00.
- Check 'G' line 0: at vcount 368/369, hcount 440+2k and 441+2k both equal font_rom['G',0] bit 7−k. Space cell (hcount 504..519) is always passthrough.
- Blink: count 32 frames in OVER_SHOW → banner absent frames 32..63, present again at frame 64.
- Restart edge at frame 10 → no pulse, state unchanged. Restart edge at frame 61 → game_reset high exactly 1 cycle, play_en=1. game_over_in+restart together in PLAY → OVER_WAIT, no pulse.
- Assert rst during OVER_SHOW → next cycle play_en=1, game_reset=0, no banner. game_over_in held high after restart → re-enters OVER_WAIT within 1 cycle.
